// File: rtl/cpu_seq_pkg.sv
// Shared types and default constants for the CPU stage sequencer.
package cpu_seq_pkg;

  // Encoding is visible on state_dbg, so the values are fixed.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExecute = 3'd3,
    StResult  = 3'd4,
    StDone    = 3'd7
  } state_e;

  localparam int unsigned DefAddrW      = 11;
  localparam int unsigned DefDataW      = 32;
  localparam int unsigned DefPcW        = 32;
  localparam int unsigned DefExecCycles = 1;
  localparam int unsigned DefResetPc    = 0;
  localparam int unsigned DefCntW       = 16;
  localparam int unsigned DefWdogCycles = 255;
  localparam int unsigned ExecCntW      = 4;

endpackage

// File: rtl/cpu_seq_mem_mux.sv
// State-selected shared memory-port multiplexer: fetch address in FETCH,
// result write in RESULT, all zero otherwise.
module cpu_seq_mem_mux
  import cpu_seq_pkg::*;
#(
  parameter int unsigned AddrW = DefAddrW,
  parameter int unsigned DataW = DefDataW
) (
  input  state_e             state_i,
  input  logic [AddrW-1:0]   fi_addr_i,
  input  logic [AddrW-1:0]   rm_addr_i,
  input  logic [DataW-1:0]   rm_wdata_i,
  input  logic               rm_we_i,
  output logic [AddrW-1:0]   address_o,
  output logic [DataW-1:0]   data_write_o,
  output logic               write_enable_o
);

  always_comb begin
    address_o      = '0;
    data_write_o   = '0;
    write_enable_o = 1'b0;
    case (state_i)
      StFetch: address_o = fi_addr_i;
      StResult: begin
        address_o      = rm_addr_i;
        data_write_o   = rm_wdata_i;
        write_enable_o = rm_we_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Fetch/decode/execute/result sequencer driving a shared memory port.
// Optional handshake watchdog is enabled by defining CPU_SEQ_WATCHDOG_EN.
module cpu_stage_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned PC_W        = DefPcW,
  parameter int unsigned EXEC_CYCLES = DefExecCycles,
  parameter int unsigned RESET_PC    = DefResetPc,
  parameter int unsigned CNT_W       = DefCntW
`ifdef CPU_SEQ_WATCHDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES = DefWdogCycles
`endif
) (
  input  logic              CLOCK_50,
  input  logic              resetIn,
  input  logic              enable,
  output logic              acknowledge,
  input  logic              run_mode,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  output logic              fi_en,
  input  logic              fi_ack,
  input  logic [ADDR_W-1:0] fi_addr,
  output logic              rm_en,
  input  logic              rm_ack,
  input  logic [ADDR_W-1:0] rm_addr,
  input  logic [DATA_W-1:0] rm_wdata,
  input  logic              rm_we,
  input  logic [PC_W-1:0]   rm_pc_next,
  input  logic              exit_code,
  output logic              ir_load,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataWrite,
  output logic              writeEnable,
  output logic [PC_W-1:0]   pc,
  output logic [CNT_W-1:0]  instr_count,
  output logic [2:0]        state_dbg,
  output logic              err,
  output logic              exited
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ExecCntW-1:0] exec_q, exec_d;
  logic                exited_q, exited_d;
  logic                err_q, err_d;

`ifdef CPU_SEQ_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             wdog_expired;
  assign wdog_expired = (wdog_q == WdogW'(WDOG_CYCLES - 1));
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    exec_d   = exec_q;
    exited_d = exited_q;
    err_d    = err_q;
`ifdef CPU_SEQ_WATCHDOG_EN
    wdog_d   = '0;
`endif
    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d  = StFetch;
          exited_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      StFetch: begin
        if (fi_ack) begin
          state_d = StDecode;
        end
`ifdef CPU_SEQ_WATCHDOG_EN
        else if (wdog_expired) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      StDecode: begin
        if (exit_code) begin
          state_d  = StDone;
          pc_d     = PC_W'(RESET_PC);
          exited_d = 1'b1;
        end else begin
          state_d = StExecute;
          exec_d  = ExecCntW'(EXEC_CYCLES - 1);
        end
      end
      StExecute: begin
        if (exec_q == '0) state_d = StResult;
        else              exec_d  = exec_q - 1'b1;
      end
      StResult: begin
        if (rm_ack) begin
          pc_d = rm_pc_next;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (run_mode && !(bp_en && (rm_pc_next == bp_addr))) state_d = StFetch;
          else                                                state_d = StDone;
        end
`ifdef CPU_SEQ_WATCHDOG_EN
        else if (wdog_expired) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      StDone: begin
        if (!enable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetIn) begin
    if (!resetIn) begin
      state_q  <= StIdle;
      pc_q     <= PC_W'(RESET_PC);
      cnt_q    <= '0;
      exec_q   <= '0;
      exited_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef CPU_SEQ_WATCHDOG_EN
      wdog_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      exec_q   <= exec_d;
      exited_q <= exited_d;
      err_q    <= err_d;
`ifdef CPU_SEQ_WATCHDOG_EN
      wdog_q   <= wdog_d;
`endif
    end
  end

  assign fi_en       = (state_q == StFetch);
  assign ir_load     = (state_q == StFetch);
  assign rm_en       = (state_q == StResult);
  assign acknowledge = (state_q == StDone);
  assign state_dbg   = state_q;
  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign exited      = exited_q;
`ifdef CPU_SEQ_WATCHDOG_EN
  assign err         = err_q;
`else
  // No watchdog: err can never be raised.
  assign err         = 1'b0;
`endif

  cpu_seq_mem_mux #(
    .AddrW(ADDR_W),
    .DataW(DATA_W)
  ) u_mem_mux (
    .state_i       (state_q),
    .fi_addr_i     (fi_addr),
    .rm_addr_i     (rm_addr),
    .rm_wdata_i    (rm_wdata),
    .rm_we_i       (rm_we),
    .address_o     (address),
    .data_write_o  (dataWrite),
    .write_enable_o(writeEnable)
  );

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Scoreboard bench for cpu_stage_sequencer (EXEC_CYCLES=3); the watchdog case
// runs only when CPU_SEQ_WATCHDOG_EN is defined.
module tb_cpu_stage_sequencer;

  logic        CLOCK_50 = 1'b0;
  logic        resetIn;
  logic        enable, acknowledge, run_mode, bp_en;
  logic [31:0] bp_addr;
  logic        fi_en, fi_ack, rm_en, rm_ack, rm_we, exit_code, ir_load;
  logic [10:0] fi_addr, rm_addr, address;
  logic [31:0] rm_wdata, rm_pc_next, dataWrite, pc;
  logic        writeEnable, err, exited;
  logic [15:0] instr_count;
  logic [2:0]  state_dbg;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] cnt;
    logic        exited;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic ack_prev = 1'b0;
  logic exit_arm, dec_clr;
  int   dec_cnt;

  always #10 CLOCK_50 = ~CLOCK_50;

  cpu_stage_sequencer #(
    .EXEC_CYCLES(3)
`ifdef CPU_SEQ_WATCHDOG_EN
    , .WDOG_CYCLES(8)
`endif
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetIn    (resetIn),
    .enable     (enable),
    .acknowledge(acknowledge),
    .run_mode   (run_mode),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .fi_en      (fi_en),
    .fi_ack     (fi_ack),
    .fi_addr    (fi_addr),
    .rm_en      (rm_en),
    .rm_ack     (rm_ack),
    .rm_addr    (rm_addr),
    .rm_wdata   (rm_wdata),
    .rm_we      (rm_we),
    .rm_pc_next (rm_pc_next),
    .exit_code  (exit_code),
    .ir_load    (ir_load),
    .address    (address),
    .dataWrite  (dataWrite),
    .writeEnable(writeEnable),
    .pc         (pc),
    .instr_count(instr_count),
    .state_dbg  (state_dbg),
    .err        (err),
    .exited     (exited)
  );

  // Program model: each instruction advances the PC by 4; exit on the 5th decode.
  assign rm_pc_next = pc + 32'd4;
  assign exit_code  = exit_arm && (state_dbg == 3'd2) && (dec_cnt == 4);

  always @(posedge CLOCK_50) begin
    if (dec_clr)                dec_cnt <= 0;
    else if (state_dbg == 3'd2) dec_cnt <= dec_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every new acknowledge retires one scoreboard entry.
  always @(negedge CLOCK_50) begin
    if (acknowledge && !ack_prev) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_ack", 64'd1, 64'd0);
      end else begin
        cur = exp_q.pop_front();
        check("sb_pc", 64'(pc), 64'(cur.pc));
        check("sb_instr_count", 64'(instr_count), 64'(cur.cnt));
        check("sb_exited", 64'(exited), 64'(cur.exited));
        check("sb_err", 64'(err), 64'(cur.err));
      end
    end
    ack_prev <= acknowledge;
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    resetIn = 1'b0;
    dec_clr = 1'b1;
    enable  = 1'b0;
    repeat (2) tick();
    resetIn = 1'b1;
    dec_clr = 1'b0;
    tick();
  endtask

  // Wait for acknowledge with a cycle budget; returns the cycle count.
  task automatic wait_ack(input string name, input int budget, output int cycles);
    cycles = 0;
    while (!acknowledge && cycles < budget) begin
      tick();
      cycles++;
    end
    if (!acknowledge) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int cyc;
    resetIn  = 1'b0;
    enable   = 1'b0;
    run_mode = 1'b0;
    bp_en    = 1'b0;
    bp_addr  = 32'h0;
    fi_ack   = 1'b1;
    rm_ack   = 1'b1;
    fi_addr  = 11'h123;
    rm_addr  = 11'h000;
    rm_wdata = 32'h0;
    rm_we    = 1'b0;
    exit_arm = 1'b0;
    dec_clr  = 1'b1;
    #25;
    check("rst_state", 64'(state_dbg), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_count", 64'(instr_count), 64'd0);
    check("rst_strobes", {59'd0, acknowledge, fi_en, rm_en, ir_load, writeEnable}, 64'd0);
    check("rst_flags", {62'd0, err, exited}, 64'd0);
    do_reset();

    // Single instruction; enable dropped mid-instruction must be ignored.
    exp_q.push_back('{pc: 32'd4, cnt: 16'd1, exited: 1'b0, err: 1'b0});
    enable = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    cyc = 2;
    while (!acknowledge && cyc < 40) begin
      tick();
      cyc++;
    end
    check("single_latency", 64'(cyc), 64'd7);
    tick();
    check("done_to_idle", 64'(state_dbg), 64'd0);

    // Run mode until exit on the 5th decode.
    do_reset();
    exp_q.push_back('{pc: 32'd0, cnt: 16'd4, exited: 1'b1, err: 1'b0});
    run_mode = 1'b1;
    exit_arm = 1'b1;
    enable   = 1'b1;
    wait_ack("exit_run", 200, cyc);
    enable   = 1'b0;
    exit_arm = 1'b0;
    tick();

    // Run mode until breakpoint at 0x10.
    do_reset();
    exp_q.push_back('{pc: 32'h10, cnt: 16'd4, exited: 1'b0, err: 1'b0});
    bp_en   = 1'b1;
    bp_addr = 32'h10;
    enable  = 1'b1;
    wait_ack("bp_run", 200, cyc);
    enable  = 1'b0;
    bp_en   = 1'b0;
    tick();

    // Memory port per state (cycle 1 FETCH, 2 DECODE, 6 RESULT).
    do_reset();
    exp_q.push_back('{pc: 32'd4, cnt: 16'd1, exited: 1'b0, err: 1'b0});
    run_mode = 1'b0;
    rm_we    = 1'b1;
    rm_addr  = 11'h02A;
    rm_wdata = 32'hDEADBEEF;
    enable   = 1'b1;
    tick();
    check("fetch_state", 64'(state_dbg), 64'd1);
    check("fetch_port", {address, dataWrite, writeEnable, fi_en, ir_load},
          {11'h123, 32'h0, 1'b0, 1'b1, 1'b1});
    tick();
    check("decode_port", {state_dbg, address, dataWrite, writeEnable}, {3'd2, 11'h0, 32'h0, 1'b0});
    tick();
    check("execute_state", 64'(state_dbg), 64'd3);
    repeat (3) tick();
    check("result_port", {state_dbg, address, dataWrite, writeEnable, rm_en},
          {3'd4, 11'h02A, 32'hDEADBEEF, 1'b1, 1'b1});
    tick();
    check("result_ack", 64'(acknowledge), 64'd1);
    enable = 1'b0;
    tick();

    // Reset mid-RESULT with a pending write.
    do_reset();
    rm_ack = 1'b0;
    enable = 1'b1;
    repeat (6) tick();
    check("held_result_we", {state_dbg, writeEnable}, {3'd4, 1'b1});
    #2 resetIn = 1'b0;
    #1;
    check("abort_we", 64'(writeEnable), 64'd0);
    check("abort_state", 64'(state_dbg), 64'd0);
    check("abort_pc", 64'(pc), 64'd0);
    enable = 1'b0;
    rm_ack = 1'b1;
    rm_we  = 1'b0;
    do_reset();

`ifdef CPU_SEQ_WATCHDOG_EN
    // Fetch ack never arrives: watchdog ends the run after 8 FETCH cycles.
    exp_q.push_back('{pc: 32'd0, cnt: 16'd0, exited: 1'b0, err: 1'b1});
    fi_ack = 1'b0;
    enable = 1'b1;
    repeat (8) tick();
    check("wdog_still_fetch", 64'(state_dbg), 64'd1);
    tick();
    check("wdog_done", {acknowledge, err}, {1'b1, 1'b1});
    enable = 1'b0;
    fi_ack = 1'b1;
    tick();
`endif

    repeat (2) tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
